puf_engine_arbiter: RTL

//  Shares one PUF mapping engine (trigger/dataIn -> done/dataOut) between two challenge requesters,
//  e.g. two SIRC test-module cores. Round-robin grant, one challenge in flight, response routed back
//  to the owning requester. Sits between the requesters' COMPUTE stages and the single mapping instance.

---
 rtl/puf_engine_arbiter_if.sv | 53 +++++
 rtl/puf_engine_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/puf_engine_arbiter_if.sv
// Bus bundle between two challenge requesters, the PUF mapping engine and the
// shared-engine arbiter. The arbiter connects through the slave modport and the
// environment (requesters, engine, status observers) through master.
interface puf_engine_arbiter_if #(
    parameter int unsigned IN_WIDTH  = 128,
    parameter int unsigned OUT_WIDTH = 16
);
    // requester 0
    logic                 req0_valid;
    logic [IN_WIDTH-1:0]  req0_challenge;
    logic                 req0_accept;
    logic                 rsp0_valid;
    logic [OUT_WIDTH-1:0] rsp0_data;
    logic                 rsp0_err;
    logic                 rsp0_ack;
    // requester 1
    logic                 req1_valid;
    logic [IN_WIDTH-1:0]  req1_challenge;
    logic                 req1_accept;
    logic                 rsp1_valid;
    logic [OUT_WIDTH-1:0] rsp1_data;
    logic                 rsp1_err;
    logic                 rsp1_ack;
    // mapping engine
    logic                 eng_trigger;
    logic [IN_WIDTH-1:0]  eng_dataIn;
    logic                 eng_done;
    logic [OUT_WIDTH-1:0] eng_dataOut;
    // status
    logic                 busy;
    logic                 grant_id;
    logic                 timeout_seen;

    modport slave (
        input  req0_valid, req0_challenge, rsp0_ack,
        input  req1_valid, req1_challenge, rsp1_ack,
        input  eng_done, eng_dataOut,
        output req0_accept, rsp0_valid, rsp0_data, rsp0_err,
        output req1_accept, rsp1_valid, rsp1_data, rsp1_err,
        output eng_trigger, eng_dataIn,
        output busy, grant_id, timeout_seen
    );

    modport master (
        output req0_valid, req0_challenge, rsp0_ack,
        output req1_valid, req1_challenge, rsp1_ack,
        output eng_done, eng_dataOut,
        input  req0_accept, rsp0_valid, rsp0_data, rsp0_err,
        input  req1_accept, rsp1_valid, rsp1_data, rsp1_err,
        input  eng_trigger, eng_dataIn,
        input  busy, grant_id, timeout_seen
    );
endinterface

// File: rtl/puf_engine_arbiter.sv
// Two-requester round-robin arbiter in front of a single PUF mapping engine.
// One challenge in flight; the response is routed back to the owner and held
// until that owner acknowledges it.
// Optional feature: define PUF_ARB_TIMEOUT_EN to abort a WAIT_DONE that lasts
// TIMEOUT_CYCLES cycles (response data 0, per-requester err flag, sticky
// timeout_seen). Without it the arbiter waits for eng_done indefinitely.
module puf_engine_arbiter #(
    parameter int unsigned IN_WIDTH       = 128,
    parameter int unsigned OUT_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    puf_engine_arbiter_if.slave   bus
);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_RETURN    = 2'd3
    } state_t;

    state_t               r_state,        w_state;
    logic                 r_last_grant,   w_last_grant;
    logic                 r_grant_id,     w_grant_id;
    logic [IN_WIDTH-1:0]  r_data_in,      w_data_in;
    logic [OUT_WIDTH-1:0] r_rsp_data,     w_rsp_data;
    logic [1:0]           r_rsp_err,      w_rsp_err;
    logic [1:0]           r_rsp_valid,    w_rsp_valid;
    logic [1:0]           r_accept,       w_accept;
    logic                 r_trigger,      w_trigger;
    logic                 r_busy,         w_busy;
    logic                 r_timeout_seen, w_timeout_seen;
    logic [CNT_W-1:0]     r_cnt,          w_cnt;
    logic                 w_winner;
    logic                 w_owner_ack;

`ifdef PUF_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    // State and output registers; the in-flight transaction is dropped on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_last_grant   <= 1'b1;
            r_grant_id     <= 1'b0;
            r_data_in      <= '0;
            r_rsp_data     <= '0;
            r_rsp_err      <= '0;
            r_rsp_valid    <= '0;
            r_accept       <= '0;
            r_trigger      <= 1'b0;
            r_busy         <= 1'b0;
            r_timeout_seen <= 1'b0;
            r_cnt          <= '0;
        end else begin
            r_state        <= w_state;
            r_last_grant   <= w_last_grant;
            r_grant_id     <= w_grant_id;
            r_data_in      <= w_data_in;
            r_rsp_data     <= w_rsp_data;
            r_rsp_err      <= w_rsp_err;
            r_rsp_valid    <= w_rsp_valid;
            r_accept       <= w_accept;
            r_trigger      <= w_trigger;
            r_busy         <= w_busy;
            r_timeout_seen <= w_timeout_seen;
            r_cnt          <= w_cnt;
        end
    end

    // Next-state and next-output logic; accept/trigger are computed as pulses.
    always_comb begin
        w_state        = r_state;
        w_last_grant   = r_last_grant;
        w_grant_id     = r_grant_id;
        w_data_in      = r_data_in;
        w_rsp_data     = r_rsp_data;
        w_rsp_err      = r_rsp_err;
        w_rsp_valid    = r_rsp_valid;
        w_accept       = '0;
        w_trigger      = 1'b0;
        w_timeout_seen = r_timeout_seen;
        w_cnt          = r_cnt;
        w_winner       = 1'b0;
        w_owner_ack    = r_grant_id ? bus.rsp1_ack : bus.rsp0_ack;

        case (r_state)
            S_IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    // Contention goes to whoever was not served last.
                    if (bus.req0_valid && bus.req1_valid) begin
                        w_winner = ~r_last_grant;
                    end else begin
                        w_winner = bus.req1_valid;
                    end
                    w_data_in          = w_winner ? bus.req1_challenge : bus.req0_challenge;
                    w_grant_id         = w_winner;
                    w_last_grant       = w_winner;
                    w_accept[w_winner] = 1'b1;
                    w_trigger          = 1'b1;
                    w_state            = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_cnt   = '0;
                w_state = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.eng_done) begin
                    w_rsp_data              = bus.eng_dataOut;
                    w_rsp_err               = '0;
                    w_rsp_valid[r_grant_id] = 1'b1;
                    w_state                 = S_RETURN;
`ifdef PUF_ARB_TIMEOUT_EN
                end else if (r_cnt == TO_LAST) begin
                    w_rsp_data              = '0;
                    w_rsp_err               = '0;
                    w_rsp_err[r_grant_id]   = 1'b1;
                    w_rsp_valid[r_grant_id] = 1'b1;
                    w_timeout_seen          = 1'b1;
                    w_state                 = S_RETURN;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
`endif
                end
            end
            S_RETURN: begin
                if (w_owner_ack) begin
                    w_rsp_valid = '0;
                    w_state     = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    // Registered outputs onto the bus.
    assign bus.req0_accept  = r_accept[0];
    assign bus.req1_accept  = r_accept[1];
    assign bus.rsp0_valid   = r_rsp_valid[0];
    assign bus.rsp1_valid   = r_rsp_valid[1];
    assign bus.rsp0_data    = r_rsp_data;
    assign bus.rsp1_data    = r_rsp_data;
    assign bus.rsp0_err     = r_rsp_err[0];
    assign bus.rsp1_err     = r_rsp_err[1];
    assign bus.eng_trigger  = r_trigger;
    assign bus.eng_dataIn   = r_data_in;
    assign bus.busy         = r_busy;
    assign bus.grant_id     = r_grant_id;
    assign bus.timeout_seen = r_timeout_seen;

endmodule
